// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory req/ack bus between the MEM-stage controller and data memory
// Purpose: bundles the variable-latency data-memory handshake.
// Signals:
//   dmem_req   master->slave  request, held until dmem_ack
//   dmem_we    master->slave  1 = write, 0 = read; valid while dmem_req
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_wdata master->slave  store data
//   dmem_ack   slave->master  one-cycle completion strobe
//   dmem_rdata slave->master  read data, valid with dmem_ack
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [31:0]       dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage controller: data-memory req/ack handshake, pipeline stall, MEM/WB register
// Purpose: takes the EX/MEM outputs, issues loads/stores to a variable-latency
//   memory, stalls the pipeline while an access is outstanding and registers
//   the write-back signals.
// Optional feature: define MEM_TIMEOUT_EN to add a WAIT-cycle counter, the
//   TIMEOUT_CYC parameter and the Timeout output.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   MEM_ALU_Result/StoreData/Rdst    EX/MEM data (address, store data, dest reg)
//   MEM_RegW/MemR/MemW               EX/MEM controls
//   dmem                             data-memory bus (master side)
//   Stall                            freezes EX/MEM and upstream registers
//   WB_Result/WB_Rdst/WB_RegW        MEM/WB register outputs
//   Misalign                         one-cycle pulse on a misaligned access
//   Timeout                          one-cycle pulse on an aborted access (MEM_TIMEOUT_EN only)
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         MEM_ALU_Result,
  input  logic [DATA_W-1:0]   MEM_StoreData,
  input  logic [4:0]          MEM_Rdst,
  input  logic                MEM_RegW,
  input  logic                MEM_MemR,
  input  logic                MEM_MemW,
  mem_access_ctrl_if.master   dmem,
  output logic                Stall,
  output logic [DATA_W-1:0]   WB_Result,
  output logic [4:0]          WB_Rdst,
  output logic                WB_RegW,
  output logic                Misalign
`ifdef MEM_TIMEOUT_EN
  , output logic              Timeout
`endif
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wb_result_q, wb_result_d;
  logic [4:0]          wb_rdst_q, wb_rdst_d;
  logic                wb_regw_q, wb_regw_d;
  logic                misalign_q, misalign_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  logic mem_op;
  logic aligned;

  assign mem_op  = MEM_MemR | MEM_MemW;
  assign aligned = (MEM_ALU_Result[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_result_d = wb_result_q;
    wb_rdst_d   = wb_rdst_q;
    wb_regw_d   = wb_regw_q;
    misalign_d  = 1'b0;
    Stall       = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_result_d = DATA_W'(MEM_ALU_Result);
          wb_rdst_d   = MEM_Rdst;
          wb_regw_d   = MEM_RegW;
        end else if (aligned) begin
          Stall     = 1'b1;
          req_d     = 1'b1;
          // A combined load+store request is treated as a store.
          we_d      = MEM_MemW;
          addr_d    = {MEM_ALU_Result[31:2], 2'b00};
          wdata_d   = MEM_StoreData;
          wb_regw_d = 1'b0;
          state_d   = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          // Misaligned access is squashed without touching memory.
          misalign_d = 1'b1;
          wb_regw_d  = 1'b0;
        end
      end
      WAIT: begin
        Stall = !dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          req_d       = 1'b0;
          wb_result_d = MEM_MemW ? DATA_W'(MEM_ALU_Result) : dmem.dmem_rdata;
          wb_rdst_d   = MEM_Rdst;
          wb_regw_d   = MEM_RegW & ~MEM_MemW;
          state_d     = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        // The counter holds the number of completed WAIT cycles, so the
        // abort lands in the TIMEOUT_CYC-th unacknowledged WAIT cycle.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          Stall     = 1'b0;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          wb_regw_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_result_q <= '0;
      wb_rdst_q   <= '0;
      wb_regw_q   <= 1'b0;
      misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_result_q <= wb_result_d;
      wb_rdst_q   <= wb_rdst_d;
      wb_regw_q   <= wb_regw_d;
      misalign_q  <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign WB_Result       = wb_result_q;
  assign WB_Rdst         = wb_rdst_q;
  assign WB_RegW         = wb_regw_q;
  assign Misalign        = misalign_q;
`ifdef MEM_TIMEOUT_EN
  assign Timeout         = timeout_q;
`endif

endmodule
